// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, oversampling edge counter,
// LSB-first data assembly, optional parity and stop-bit checking with strobed results.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_serial_data_in,
    input  logic [4:0]            i_prescale,
    input  logic                  i_parity_enable,
    input  logic                  i_parity_type,
    input  logic                  i_sampled_bit,
    output logic                  o_sampler_enable,
    output logic [4:0]            o_edge_count,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_valid,
    output logic                  o_parity_error,
    output logic                  o_stop_error
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    // IDLE wait for low line | START confirm start bit | DATA shift bits | PARITY check | STOP check and deliver
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [4:0]              r_edge_cnt;
    logic [4:0]              r_prescale_q;
    logic                    r_par_en_q;
    logic                    r_par_type_q;
    logic [BW-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_par_bad;
    logic                    r_data_valid;
    logic                    r_parity_error;
    logic                    r_stop_error;

    logic w_bit_end;
    logic w_load_cfg;
    logic w_start_end;
    logic w_shift;
    logic w_par_chk;
    logic w_stop_end;
    logic w_par_mismatch;

    assign w_bit_end      = (r_state != IDLE) && (r_edge_cnt == (r_prescale_q - 5'd1));
    assign w_par_mismatch = i_sampled_bit != ((^r_shift) ^ r_par_type_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_cfg  = 1'b0;
        w_start_end = 1'b0;
        w_shift     = 1'b0;
        w_par_chk   = 1'b0;
        w_stop_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_serial_data_in) begin
                    w_load_cfg  = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_start_end = 1'b1;
                    w_state_nxt = i_sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = r_par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_par_chk   = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_stop_end  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_edge_cnt     <= 5'd0;
            r_prescale_q   <= 5'd0;
            r_par_en_q     <= 1'b0;
            r_par_type_q   <= 1'b0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_data_out     <= '0;
            r_par_bad      <= 1'b0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
        end else begin
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;

            if (r_state == IDLE || w_bit_end) begin
                r_edge_cnt <= 5'd0;
            end else begin
                r_edge_cnt <= r_edge_cnt + 5'd1;
            end

            // Frame configuration is frozen for the whole frame once the start edge is seen
            if (w_load_cfg) begin
                r_prescale_q <= i_prescale;
                r_par_en_q   <= i_parity_enable;
                r_par_type_q <= i_parity_type;
                r_par_bad    <= 1'b0;
            end

            if (w_start_end) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end

            if (w_shift) begin
                r_shift <= {i_sampled_bit, r_shift[DATA_WIDTH-1:1]};
            end

            if (w_par_chk && w_par_mismatch) begin
                r_par_bad      <= 1'b1;
                r_parity_error <= 1'b1;
            end

            if (w_stop_end) begin
                if (!i_sampled_bit) begin
                    r_stop_error <= 1'b1;
                end else if (!r_par_bad) begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                end
            end
        end
    end

    assign o_sampler_enable = (r_state != IDLE);
    assign o_edge_count     = r_edge_cnt;
    assign o_data_out       = r_data_out;
    assign o_data_valid     = r_data_valid;
    assign o_parity_error   = r_parity_error;
    assign o_stop_error     = r_stop_error;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames push expected strobes,
// a negedge monitor pops and compares kind, data_out and strobe cycle.
module tb_uart_rx_frame_ctrl;

    localparam int DW = 8;
    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PAR   = 3'b010;
    localparam logic [2:0] K_STOP  = 3'b001;
    localparam logic [2:0] K_NONE  = 3'b000;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic [4:0]    prescale;
    logic          par_en;
    logic          par_type;
    logic          sampled;
    logic          sampler_enable;
    logic [4:0]    edge_count;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string      name;
        logic [2:0] kind;
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t sb[$];

    uart_rx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_serial_data_in (serial_in),
        .i_prescale       (prescale),
        .i_parity_enable  (par_en),
        .i_parity_type    (par_type),
        .i_sampled_bit    (sampled),
        .o_sampler_enable (sampler_enable),
        .o_edge_count     (edge_count),
        .o_data_out       (data_out),
        .o_data_valid     (data_valid),
        .o_parity_error   (parity_error),
        .o_stop_error     (stop_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (data_valid || parity_error || stop_error) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {29'd0, data_valid, parity_error, stop_error}, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_kind"}, {29'd0, data_valid, parity_error, stop_error}, {29'd0, e.kind});
                chk({e.name, "_data"}, {24'd0, data_out}, {24'd0, e.data});
                chk({e.name, "_cycle"}, cyc, e.when);
            end
        end
    end

    // Called at a negedge; the DUT sees the low line at the following posedge.
    task automatic send_frame(input string name, input logic [7:0] data, input int p,
                              input bit pe, input bit pbit, input bit sbit,
                              input logic [2:0] kind, input logic [7:0] exp_data);
        exp_t e;
        int   bits_before;
        bits_before = (kind == K_PAR) ? (1 + DW) : (1 + DW + int'(pe));
        if (kind != K_NONE) begin
            e.name = name;
            e.kind = kind;
            e.data = exp_data;
            e.when = cyc + (bits_before + 1) * p + 1;
            sb.push_back(e);
        end
        serial_in = 1'b0;
        sampled   = 1'b0;
        repeat (p + 1) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            serial_in = data[i];
            sampled   = data[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            serial_in = pbit;
            sampled   = pbit;
            repeat (p) @(negedge clk);
        end
        serial_in = sbit;
        sampled   = sbit;
        repeat (p) @(negedge clk);
        serial_in = 1'b1;
        sampled   = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_missing_strobes"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        rst       = 1'b1;
        serial_in = 1'b1;
        sampled   = 1'b1;
        prescale  = 5'd8;
        par_en    = 1'b0;
        par_type  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sampler_enable", sampler_enable, 0);
        chk("rst_edge_count", edge_count, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_parity_error", parity_error, 0);
        chk("rst_stop_error", stop_error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_frame("a5_p8", 8'hA5, 8, 0, 0, 1, K_VALID, 8'hA5);
        drain("a5_p8");

        prescale = 5'd16;
        par_en   = 1'b1;
        par_type = 1'b0;
        send_frame("3c_even_ok", 8'h3C, 16, 1, 0, 1, K_VALID, 8'h3C);
        drain("3c_even_ok");
        send_frame("3c_even_bad", 8'h3C, 16, 1, 1, 1, K_PAR, 8'h3C);
        drain("3c_even_bad");

        prescale = 5'd5;
        par_type = 1'b1;
        send_frame("07_odd_ok", 8'h07, 5, 1, 0, 1, K_VALID, 8'h07);
        drain("07_odd_ok");

        prescale = 5'd8;
        par_en   = 1'b0;
        par_type = 1'b0;
        serial_in = 1'b0;
        sampled   = 1'b1;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        @(negedge clk);
        chk("glitch_edge_count", edge_count, 3);
        chk("glitch_sampler_en", sampler_enable, 1);
        repeat (4) @(negedge clk);
        chk("glitch_last_edge", edge_count, 7);
        @(negedge clk);
        chk("glitch_back_idle", sampler_enable, 0);
        chk("glitch_idle_edge", edge_count, 0);
        drain("glitch");
        send_frame("12_after_glitch", 8'h12, 8, 0, 0, 1, K_VALID, 8'h12);
        drain("12_after_glitch");

        send_frame("ff_stop_bad", 8'hFF, 8, 0, 0, 0, K_STOP, 8'h12);
        drain("ff_stop_bad");

        prescale = 5'd4;
        fork
            begin
                send_frame("b2b_01", 8'h01, 4, 0, 0, 1, K_VALID, 8'h01);
                send_frame("b2b_80", 8'h80, 8, 0, 0, 1, K_VALID, 8'h80);
            end
            begin
                repeat (10) @(negedge clk);
                prescale = 5'd8;
            end
        join
        drain("b2b");

        serial_in = 1'b0;
        sampled   = 1'b0;
        repeat (8 + 1 + 4 * 8 + 3) @(negedge clk);
        serial_in = 1'b1;
        sampled   = 1'b1;
        chk("pre_rst_sampler_en", sampler_enable, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sampler_en", sampler_enable, 0);
        chk("mid_rst_edge_count", edge_count, 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_strobes", {29'd0, data_valid, parity_error, stop_error}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_sampler_en", sampler_enable, 0);
        chk("post_rst_edge_count", edge_count, 0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame controller for the UART receiver. It detects the start-bit falling edge and generates the oversampling edge counter and sampler enable for the data sampler. It consumes the majority-voted sampled_bit, assembles an LSB-first data word, checks optional parity and the stop bit, and presents the received word with a one-cycle valid strobe to the downstream consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9)

Ports:
clk  input  1  receiver oversampling clock
reset  input  1  asynchronous, active-high reset
serial_data_in  input  1  raw RX line (idle high), already synchronised
prescale  input  5  oversampling ratio, clk edges per bit; legal 4..31
parity_enable  input  1  1 = frame carries a parity bit after data
parity_type  input  1  0 = even, 1 = odd
sampled_bit  input  1  voted bit from data sampler, valid when edge_count == prescale_q-1
sampler_enable  output  1  high in every non-IDLE state
edge_count  output  5  edge index within current bit, 0..prescale_q-1
data_out  output  DATA_WIDTH  last good received word
data_valid  output  1  one-cycle strobe, data_out updated
parity_error  output  1  one-cycle strobe, parity mismatch
stop_error  output  1  one-cycle strobe, stop bit sampled 0

Behaviour:
- Reset (async, active-high): state IDLE; edge_count=0, bit counter=0, shift register=0, data_out=0, sampler_enable=0, data_valid=0, parity_error=0, stop_error=0. Reset mid-frame abandons the frame with no strobes.
- prescale_q: prescale latched on the IDLE->START transition. Changes to prescale mid-frame are ignored.
- "Bit end" = edge_count == prescale_q-1 while sampler_enable=1. edge_count increments every cycle in non-IDLE states and wraps to 0 at bit end. It is held at 0 in IDLE.
- States:
  - IDLE: serial_data_in==0 -> START (edge_count=0 next cycle); else stay.
  - START: at bit end, if sampled_bit==1 (glitch), go to IDLE with no strobes. Else go to DATA with bit counter=0.
  - DATA: at each bit end, shift sampled_bit in LSB-first (bit k lands in position k). Increment the bit counter. After DATA_WIDTH bits, go to PARITY if parity_enable, else STOP. parity_enable and parity_type are latched with prescale_q.
  - PARITY: at bit end, the expected bit is the XOR of the data bits XOR parity_type. On mismatch, set an internal par_bad flag and pulse parity_error the next cycle. Go to STOP.
  - STOP: at bit end, go to IDLE. If sampled_bit==0, pulse stop_error. If sampled_bit==1 and par_bad==0, load data_out and pulse data_valid.
- Strobe timing: data_valid, parity_error and stop_error are registered. Each is high for exactly the one cycle after the deciding bit end.
- data_out holds its value between frames. It is never updated on an errored frame.
- Back-to-back frames: after STOP the block spends at least one cycle in IDLE. A line already low in that cycle starts the next frame immediately.
- Frame length, from the start-detect cycle to the strobe cycle: (1 + DATA_WIDTH + parity_enable + 1) * prescale_q + 1 cycles.

Test Plan:
- prescale=8, no parity, frame 0xA5 with a clean stop -> data_out=0xA5, data_valid high for 1 cycle, 81 cycles after start detect; parity_error=stop_error=0.
- prescale=16, parity_enable=1, parity_type=0, frame 0x3C with parity bit 0 -> data_valid, data_out=0x3C. Repeat with parity bit 1 -> parity_error pulse, no data_valid, data_out keeps 0x3C.
- prescale=8, line low for 3 cycles then high (sampled start=1) -> return to IDLE after 8 cycles with no strobes. Then a valid 0x12 frame is received correctly.
- prescale=8, frame 0xFF with stop bit 0 -> stop_error pulse only, data_out unchanged.
- Two back-to-back frames 0x01, 0x80 with no idle gap, prescale=4 -> two data_valid strobes carrying 0x01 then 0x80. prescale changed to 8 mid-frame does not alter the first frame's timing.
- Assert reset during DATA bit 4 -> all outputs 0 immediately. After release, the line idle-high keeps the block in IDLE with edge_count=0.
